// File: rtl/cpu_if_nway_pkg.sv
// Shared types and constants for the multi-lane instruction fetch unit.
// Holds the address/word typedefs, the NOP encoding and the default reset PC.
package cpu_if_nway_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;

  localparam word_t NOP              = 32'h0000_0013;
  localparam addr_t RESET_PC_DEFAULT = 32'h0000_0000;

  // Lane i of a fetch group reads the word at base + 4*i (modulo 2^32).
  function automatic addr_t lane_pc(input addr_t base, input int lane);
    return base + (addr_t'(lane) << 2);
  endfunction

endpackage

// File: rtl/cpu_if_nway_fetch_queue.sv
// Circular fetch queue: up to FETCH_W pushes and FETCH_W pops per cycle.
// Counts arrive pre-clamped from the fetch unit; head lanes are read combinationally.
module fetch_queue
  import cpu_if_nway_pkg::*;
#(
  parameter int FETCH_W = 2,
  parameter int QDEPTH  = 8,
  localparam int CW = $clog2(FETCH_W + 1),
  localparam int PW = $clog2(QDEPTH),
  localparam int OW = PW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [CW-1:0]          push_cnt,
  input  logic [32*FETCH_W-1:0]  push_pc,
  input  logic [32*FETCH_W-1:0]  push_inst,
  input  logic [CW-1:0]          pop_cnt,
  output logic [OW-1:0]          occ,
  output logic [FETCH_W-1:0]     deq_valid,
  output logic [32*FETCH_W-1:0]  deq_pc,
  output logic [32*FETCH_W-1:0]  deq_inst
);

  addr_t          pc_mem   [QDEPTH];
  word_t          inst_mem [QDEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [OW-1:0]  cnt;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + PW'(pop_cnt);
      tail <= tail + PW'(push_cnt);
      cnt  <= cnt + OW'(push_cnt) - OW'(pop_cnt);
    end
  end

  // Storage carries no reset; only the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (CW'(i) < push_cnt) begin
          pc_mem[tail + PW'(i)]   <= push_pc[32*i +: 32];
          inst_mem[tail + PW'(i)] <= push_inst[32*i +: 32];
        end
      end
    end
  end

  always_comb begin
    deq_valid = '0;
    deq_pc    = '0;
    deq_inst  = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      if (cnt > OW'(i)) begin
        deq_valid[i]        = 1'b1;
        deq_pc[32*i +: 32]   = pc_mem[head + PW'(i)];
        deq_inst[32*i +: 32] = inst_mem[head + PW'(i)];
      end else begin
        deq_inst[32*i +: 32] = NOP;
      end
    end
  end

  assign occ = cnt;

endmodule

// File: rtl/cpu_if_nway.sv
// N-lane instruction fetch: issues a PC to the I-cache, accepts the leading run of
// hits that fits in the fetch queue, and presents queue head lanes to decode.
module cpu_if_nway
  import cpu_if_nway_pkg::*;
#(
  parameter int    FETCH_W  = 2,
  parameter int    QDEPTH   = 8,
  parameter addr_t RESET_PC = RESET_PC_DEFAULT,
  localparam int CW = $clog2(FETCH_W + 1),
  localparam int OW = $clog2(QDEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  output logic                   req_en,
  output addr_t                  req_pc,
  input  logic [FETCH_W-1:0]     hit,
  input  logic [32*FETCH_W-1:0]  inst,
  input  logic                   redirect,
  input  addr_t                  redirect_pc,
  output logic [FETCH_W-1:0]     deq_valid,
  output logic [32*FETCH_W-1:0]  deq_pc,
  output logic [32*FETCH_W-1:0]  deq_inst,
  input  logic [CW-1:0]          deq_cnt
);

  addr_t                 pc;
  logic [OW-1:0]         occ;
  logic [OW-1:0]         free;
  logic [OW-1:0]         lead;
  logic [OW-1:0]         take;
  logic [OW-1:0]         pops;
  logic [CW-1:0]         push_cnt;
  logic [CW-1:0]         pop_cnt;
  logic [32*FETCH_W-1:0] push_pc;
  logic                  step;
  logic                  flush;
  logic                  run;

  assign step  = rdy && !redirect && !rst;
  assign flush = rdy && redirect && !rst;

  // Hits after the first miss are dropped so the queue stays in program order.
  always_comb begin
    lead = '0;
    run  = 1'b1;
    for (int i = 0; i < FETCH_W; i++) begin
      if (run && hit[i]) lead = lead + OW'(1);
      else               run  = 1'b0;
    end
  end

  // Free space uses start-of-cycle occupancy; pops in the same cycle do not help.
  assign free     = OW'(QDEPTH) - occ;
  assign take     = (lead < free) ? lead : free;
  assign pops     = (OW'(deq_cnt) < occ) ? OW'(deq_cnt) : occ;
  assign push_cnt = step ? CW'(take) : '0;
  assign pop_cnt  = step ? CW'(pops) : '0;

  always_comb begin
    push_pc = '0;
    for (int i = 0; i < FETCH_W; i++) push_pc[32*i +: 32] = lane_pc(pc, i);
  end

  assign req_en = !rst && (occ < OW'(QDEPTH));
  assign req_pc = pc;

  always_ff @(posedge clk) begin
    if (rst)        pc <= RESET_PC;
    else if (flush) pc <= redirect_pc;
    else if (step)  pc <= pc + (addr_t'(push_cnt) << 2);
  end

  fetch_queue #(
    .FETCH_W (FETCH_W),
    .QDEPTH  (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push_cnt  (push_cnt),
    .push_pc   (push_pc),
    .push_inst (inst),
    .pop_cnt   (pop_cnt),
    .occ       (occ),
    .deq_valid (deq_valid),
    .deq_pc    (deq_pc),
    .deq_inst  (deq_inst)
  );

endmodule

// File: doc/cpu_if_nway.md
CPU_IF_NWAY -- requirements
Module: cpu_if_nway

Interface
REQ-001 SHALL: parameter FETCH_W, default 2, fetch lanes per cycle (1..4).
REQ-002 SHALL: parameter QDEPTH, default 8, fetch-queue entries (power of two, >= 2*FETCH_W).
REQ-003 SHALL: parameter RESET_PC, default 32'h0, PC loaded on reset.
REQ-004 SHALL: clk  in  1  clock; all state on posedge.
REQ-005 SHALL: rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL: rdy  in  1  global enable; when low, all state holds.
REQ-007 SHALL: req_en  out  1  fetch request valid to I-cache.
REQ-008 SHALL: req_pc  out  32  PC of lane 0; lane i reads req_pc+4*i.
REQ-009 SHALL: hit  in  FETCH_W  per-lane hit, same cycle as req_pc.
REQ-010 SHALL: inst  in  32*FETCH_W  per-lane instruction word, lane i at bits [32i+31:32i].
REQ-011 SHALL: redirect  in  1  flush and restart fetch.
REQ-012 SHALL: redirect_pc  in  32  restart PC (word-aligned).
REQ-013 SHALL: deq_valid  out  FETCH_W  thermometer code: lane i valid iff queue holds > i entries.
REQ-014 SHALL: deq_pc  out  32*FETCH_W  PCs of head entries, lane 0 = oldest.
REQ-015 SHALL: deq_inst  out  32*FETCH_W  instructions of head entries.
REQ-016 SHALL: deq_cnt  in  clog2(FETCH_W+1)  entries consumed by decode this cycle.

Function
REQ-017 SHALL: accepted count k = min(length of leading run of set hit bits from lane 0, free slots); hits after a miss are discarded.
REQ-018 SHALL: on rdy && !redirect, push k (pc, inst) pairs in lane order and advance pc by 4*k; k=0 leaves pc unchanged.
REQ-019 SHALL: req_en = 1 whenever free slots > 0 and not in reset; otherwise 0 (pc held).
REQ-020 SHALL: free slots computed from occupancy at start of cycle; same-cycle pops do not create push space.
REQ-021 SHALL: pop min(deq_cnt, occupancy) entries per enabled cycle; larger deq_cnt is clamped, never underflows.
REQ-022 SHALL: deq_* outputs combinational from queue head; zero-latency bypass of same-cycle hits is not provided (minimum hit-to-deq latency 1 cycle).
REQ-023 SHALL: redirect (with rdy) empties queue, sets pc <= redirect_pc, discards same-cycle hits and ignores deq_cnt; fetch from redirect_pc starts next cycle.
REQ-024 SHALL: occupancy counter width clog2(QDEPTH)+1; head/tail pointers wrap modulo QDEPTH.
REQ-025 SHALL: simultaneous push and pop at full/empty resolve by rules REQ-020/021; occupancy = old + k - pops.
REQ-026 SHALL: pc arithmetic is 32-bit modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.

Reset
REQ-027 SHALL: on rst: pc = RESET_PC, occupancy = 0, head = tail = 0, deq_valid = 0, req_en = 0.
REQ-028 SHALL: rst overrides rdy and redirect; reset mid-operation discards all queued entries.
REQ-029 SHALL: first request issues cycle after rst deasserts, with req_pc = RESET_PC.

Structure
REQ-030 SHALL: shared package holds addr_t/word_t (32-bit) typedefs, NOP encoding and RESET_PC default.
REQ-031 SHALL: queue implemented as sub-module fetch_queue (multi-push/multi-pop circular buffer, parameters FETCH_W, QDEPTH).
REQ-032 SHALL: leading-hit count and clamping logic stay in cpu_if_nway.

Verification
REQ-033 SHALL: FETCH_W=2, all hits, deq_cnt=0 from reset -> req_pc 0,8,16,24, stalls at 8 entries, req_en=0, pc=32.
REQ-034 SHALL: hit=2'b10 at pc=0x40 -> nothing pushed, pc stays 0x40; hit=2'b01 -> one entry (0x40), pc=0x44.
REQ-035 SHALL: queue 3 entries, deq_cnt=2, hit=2'b11, free=5 -> next occupancy 3, deq_pc lane0 = old third entry.
REQ-036 SHALL: redirect to 0x1000 while queue full and hit=11 -> next cycle occupancy 0, deq_valid=0, req_pc=0x1000.
REQ-037 SHALL: rdy=0 for 3 cycles with hits and deq_cnt=2 -> pc, occupancy, outputs unchanged.
REQ-038 SHALL: FETCH_W=4, QDEPTH=8, 6 entries queued, hit=4'b1111 -> exactly 2 accepted, pc += 8.
